gol_generation_sequencer: RTL and testbench



---
 rtl/gol_pkg.sv | 9 +
 rtl/gol_wrap_addr.sv | 23 ++
 rtl/gol_generation_sequencer.sv | 119 +++++++++++
 tb/tb_gol_generation_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// gol_pkg: grid geometry, sequencer state encoding and the neighbour offset table in read order.
package gol_pkg;
  localparam int MAX_i = 14;
  localparam int MAX_j = 19;
  localparam int CW = 10;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_ACC, S_WRITE, S_DONE} state_t;
  localparam int DX [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int DY [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
endpackage

// File: rtl/gol_wrap_addr.sv
// gol_wrap_addr: maps a cell and neighbour index k to the toroidally wrapped read address.
module gol_wrap_addr
  import gol_pkg::*;
(
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  logic [3:0]    i_k,
  output logic [CW-1:0] o_rd_x,
  output logic [CW-1:0] o_rd_y
);
  int w_dx, w_dy;
  logic [CW-1:0] w_xm, w_xp, w_ym, w_yp;
  always_comb begin
    w_dx = i_k < 4'd9 ? DX[i_k] : 0;
    w_dy = i_k < 4'd9 ? DY[i_k] : 0;
    w_xm = i_x == '0 ? CW'(MAX_i) : i_x - CW'(1);
    w_xp = i_x == CW'(MAX_i) ? '0 : i_x + CW'(1);
    w_ym = i_y == '0 ? CW'(MAX_j) : i_y - CW'(1);
    w_yp = i_y == CW'(MAX_j) ? '0 : i_y + CW'(1);
    o_rd_x = w_dx < 0 ? w_xm : w_dx > 0 ? w_xp : i_x;
    o_rd_y = w_dy < 0 ? w_ym : w_dy > 0 ? w_yp : i_y;
  end
endmodule

// File: rtl/gol_generation_sequencer.sv
// gol_generation_sequencer: sweeps the toroidal grid, 11 cycles per cell, writes the next generation and swaps banks.
// Optional GOL_STABLE_DETECT_EN: o_stable reports that the last generation changed no cell.
module gol_generation_sequencer
  import gol_pkg::*;
#(
  parameter int GEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_rd_en,
  output logic [CW-1:0]    o_rd_x,
  output logic [CW-1:0]    o_rd_y,
  output logic             o_rd_bank,
  input  logic             i_rd_data,
  output logic             o_wr_en,
  output logic [CW-1:0]    o_wr_x,
  output logic [CW-1:0]    o_wr_y,
  output logic             o_wr_data,
  output logic             o_busy,
  output logic             o_gen_done,
  output logic [GEN_W-1:0] o_gen_count,
  output logic             o_stable
);
  state_t r_state, w_next;
  logic [CW-1:0] r_x, r_y, r_wr_x, r_wr_y;
  logic [3:0] r_k, r_n, w_n;
  logic r_dv, r_dself, r_self, r_wr_en, r_wr_data, r_bank, w_last, w_life;
  logic [GEN_W-1:0] r_gen;

  gol_wrap_addr u_wrap (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_k    (r_k),
    .o_rd_x (o_rd_x),
    .o_rd_y (o_rd_y)
  );

  // r_dv/r_dself describe the read issued last cycle, whose datum is on i_rd_data now
  always_comb begin
    w_last = r_x == CW'(MAX_i) && r_y == CW'(MAX_j);
    w_n = r_n + {3'b000, r_dv & ~r_dself & i_rd_data};
    w_life = w_n == 4'd3 || (r_self && w_n == 4'd2);
    w_next = r_state == S_IDLE  ? (i_start ? S_READ : S_IDLE) :
             r_state == S_READ  ? (r_k == 4'd8 ? S_ACC : S_READ) :
             r_state == S_ACC   ? S_WRITE :
             r_state == S_WRITE ? (w_last ? S_DONE : S_READ) : S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_x <= '0;
      r_y <= '0;
      r_k <= '0;
      r_n <= '0;
      r_dv <= 1'b0;
      r_dself <= 1'b0;
      r_self <= 1'b0;
      r_wr_en <= 1'b0;
      r_wr_x <= '0;
      r_wr_y <= '0;
      r_wr_data <= 1'b0;
      r_bank <= 1'b0;
      r_gen <= '0;
    end else begin
      r_state <= w_next;
      r_k <= r_state == S_READ && r_k != 4'd8 ? r_k + 4'd1 : 4'd0;
      r_dv <= r_state == S_READ;
      r_dself <= r_state == S_READ && r_k == 4'd4;
      r_n <= r_state == S_READ || r_state == S_ACC ? w_n : 4'd0;
      if (r_dv && r_dself) r_self <= i_rd_data;
      r_wr_en <= r_state == S_ACC;
      if (r_state == S_ACC) begin
        r_wr_x <= r_x;
        r_wr_y <= r_y;
        r_wr_data <= w_life;
      end
      if (r_state == S_IDLE) begin
        r_x <= '0;
        r_y <= '0;
      end else if (r_state == S_WRITE) begin
        r_x <= r_x == CW'(MAX_i) ? '0 : r_x + CW'(1);
        r_y <= r_x != CW'(MAX_i) ? r_y : r_y == CW'(MAX_j) ? '0 : r_y + CW'(1);
      end
      if (r_state == S_DONE) begin
        r_bank <= ~r_bank;
        r_gen <= r_gen + GEN_W'(1);
      end
    end
  end

  assign o_rd_en = r_state == S_READ;
  assign o_rd_bank = r_bank;
  assign o_wr_en = r_wr_en;
  assign o_wr_x = r_wr_x;
  assign o_wr_y = r_wr_y;
  assign o_wr_data = r_wr_data;
  assign o_busy = r_state != S_IDLE;
  assign o_gen_done = r_state == S_DONE;
  assign o_gen_count = r_gen;

`ifdef GOL_STABLE_DETECT_EN
  logic r_chg, r_stable;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_chg <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_start) r_chg <= 1'b0;
      else if (r_wr_en && r_wr_data != r_self) r_chg <= 1'b1;
      if (r_state == S_DONE) r_stable <= ~r_chg;
    end
  end
  assign o_stable = r_stable;
`else
  assign o_stable = 1'b0;
`endif
endmodule

// File: tb/tb_gol_generation_sequencer.sv
// tb_gol_generation_sequencer: dual-bank RAM model plus a plain-arithmetic Life reference.
module tb_gol_generation_sequencer;
  import gol_pkg::*;
  localparam int W = MAX_i + 1, H = MAX_j + 1, N = W * H, LAT = N * 11;
  typedef bit grid_t [H][W];
  typedef struct {
    int n; int cy[4]; int cx[4];
    int m; int ey[4]; int ex[4];
  } vec_t;

  logic clk = 0, rst_n = 0, start = 0, rd_data = 0;
  logic rd_en, rd_bank, wr_en, wr_data, busy, gen_done, stable;
  logic [9:0] rd_x, rd_y, wr_x, wr_y;
  logic [15:0] gen_count;
  bit mem [2][H][W];
  bit nxt;
  int checks = 0, failures = 0;
  int wr_cnt = 0, wr_bad = 0, overlap = 0, done_cnt = 0;
  int bank = 0, gens = 0, fx = 0, fy = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= nxt;

  gol_generation_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_rd_en(rd_en), .o_rd_x(rd_x), .o_rd_y(rd_y), .o_rd_bank(rd_bank), .i_rd_data(rd_data),
    .o_wr_en(wr_en), .o_wr_x(wr_x), .o_wr_y(wr_y), .o_wr_data(wr_data),
    .o_busy(busy), .o_gen_done(gen_done), .o_gen_count(gen_count), .o_stable(stable)
  );

  function automatic grid_t life(grid_t g);
    grid_t r;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) n += int'(g[(y + dy + H) % H][(x + dx + W) % W]);
        r[y][x] = n == 3 || (g[y][x] && n == 2);
      end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic snap(output grid_t g);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) g[y][x] = mem[bank][y][x];
  endtask

  task automatic load(input grid_t g);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) mem[bank][y][x] = g[y][x];
  endtask

  function automatic int diff(grid_t a, grid_t b);
    int d = 0;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) d += int'(a[y][x] != b[y][x]);
    return d;
  endfunction

  task automatic run_gen(input int poke, output int lat);
    wr_cnt = 0;
    wr_bad = 0;
    lat = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    fx = int'(rd_x);
    fy = int'(rd_y);
    while (!gen_done && lat < LAT + 200) begin
      @(negedge clk);
      lat++;
      start = lat == poke;
    end
    start = 0;
    @(negedge clk);
  endtask

  task automatic do_gen(input string name, input grid_t exp, input int poke);
    grid_t cur, got;
    int lat, est;
    snap(cur);
    run_gen(poke, lat);
    bank ^= 1;
    gens++;
    check({name, " latency"}, lat, LAT);
    check({name, " first read x"}, fx, MAX_i);
    check({name, " first read y"}, fy, MAX_j);
    check({name, " rd_bank"}, int'(rd_bank), bank);
    check({name, " gen_count"}, int'(gen_count), gens & 16'hffff);
    check({name, " writes"}, wr_cnt, N);
    check({name, " write order errors"}, wr_bad, 0);
    snap(got);
    check({name, " wrong cells"}, diff(got, exp), 0);
`ifdef GOL_STABLE_DETECT_EN
    est = int'(diff(cur, exp) == 0);
`else
    est = 0;
`endif
    check({name, " stable"}, int'(stable), est);
  endtask

  initial begin
    vec_t tab[4];
    grid_t g, e, cur, got;
    int lat, d0;
    fork
      forever begin
        @(negedge clk);
        nxt = rd_en ? mem[rd_bank][rd_y][rd_x] : 1'($urandom);
        if (rd_en && wr_en) overlap++;
        if (gen_done) done_cnt++;
        if (wr_en) begin
          if (int'(wr_x) != (wr_cnt % N) % W || int'(wr_y) != (wr_cnt % N) / W) wr_bad++;
          mem[!rd_bank][wr_y][wr_x] = wr_data;
          wr_cnt++;
        end
      end
    join_none

    tab[0] = '{3, '{5, 5, 5, 0}, '{3, 4, 5, 0}, 3, '{4, 5, 6, 0}, '{4, 4, 4, 0}};
    tab[1] = '{4, '{0, 0, 19, 19}, '{0, 14, 0, 14}, 4, '{0, 0, 19, 19}, '{0, 14, 0, 14}};
    tab[2] = '{3, '{0, 0, 0, 0}, '{13, 14, 0, 0}, 3, '{19, 0, 1, 0}, '{14, 14, 14, 0}};
    tab[3] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset rd_bank", int'(rd_bank), 0);
    check("reset gen_count", int'(gen_count), 0);
    check("reset gen_done", int'(gen_done), 0);
    check("reset stable", int'(stable), 0);
    check("reset strobes", int'(rd_en) + int'(wr_en), 0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin g[y][x] = 0; e[y][x] = 0; end
      for (int c = 0; c < tab[i].n; c++) g[tab[i].cy[c]][tab[i].cx[c]] = 1;
      for (int c = 0; c < tab[i].m; c++) e[tab[i].ey[c]][tab[i].ex[c]] = 1;
      load(g);
      do_gen($sformatf("table%0d", i), e, -1);
    end

    for (int i = 0; i < 3; i++) begin
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) g[y][x] = $urandom_range(0, 99) < 30;
      load(g);
      do_gen($sformatf("random%0d", i), life(g), -1);
    end

    snap(cur);
    d0 = done_cnt;
    do_gen("mid start", life(cur), 100);
    repeat (LAT + 20) @(negedge clk);
    check("mid start done pulses", done_cnt - d0, 1);
    check("mid start idle", int'(busy), 0);

    snap(cur);
    wr_cnt = 0;
    wr_bad = 0;
    @(negedge clk) start = 1;
    lat = 0;
    @(negedge clk);
    while (!gen_done && lat < LAT + 200) begin @(negedge clk); lat++; end
    check("b2b first latency", lat, LAT);
    @(negedge clk);
    check("b2b idle gap", int'(busy), 0);
    @(negedge clk);
    check("b2b rearm", int'(busy), 1);
    start = 0;
    lat = 0;
    while (!gen_done && lat < LAT + 200) begin @(negedge clk); lat++; end
    check("b2b second latency", lat, LAT);
    @(negedge clk);
    gens += 2;
    check("b2b gen_count", int'(gen_count), gens);
    check("b2b writes", wr_cnt, 2 * N);
    check("b2b write order errors", wr_bad, 0);
    snap(got);
    check("b2b wrong cells", diff(got, life(life(cur))), 0);

    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (1500) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("abort busy", int'(busy), 0);
    check("abort rd_bank", int'(rd_bank), 0);
    check("abort gen_count", int'(gen_count), 0);
    rst_n = 1;
    bank = 0;
    gens = 0;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) g[y][x] = $urandom_range(0, 99) < 40;
    load(g);
    do_gen("after reset", life(g), -1);

    check("rd/wr overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
